cve2_instr_bus_arbiter: RTL and testbench

Shares the core's single instruction-side bus port between two requesters. Port 0 is the IF-stage prefetch buffer fetch path. Port 1 is a secondary master, such as a debug program-buffer loader or a boot DMA. The block arbitrates requests round-robin, holds the selection stable until the request is granted, tracks outstanding transactions in order, and routes each response back to the requester that issued it. It sits between cve2_if_stage and the core's instr_* top-level pins.

---
 rtl/cve2_instr_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_cve2_instr_bus_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cve2_instr_bus_arbiter.sv
// Round-robin arbiter sharing the instruction bus between the IF fetch path and a secondary master.
// The selection is held until it is granted, and an owner FIFO routes in-order responses back to the issuer.
module cve2_instr_bus_arbiter #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic        m1_err_o,
    output logic [31:0] rdata_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(MaxOutstanding);

    logic                      rr_q, rr_d;
    logic                      lock_q, lock_d;
    logic                      lock_owner_q, lock_owner_d;
    logic [MaxOutstanding-1:0] owner_q, owner_d;
    logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]           count_q, count_d;

    logic sel_vld;
    logic sel_port;
    logic full;
    logic push;
    logic pop;
    logic head_owner;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    // A locked owner stays selected even if the other port would win round-robin.
    always_comb begin
        sel_vld  = 1'b0;
        sel_port = 1'b0;
        if (lock_q) begin
            sel_port = lock_owner_q;
            sel_vld  = lock_owner_q ? m1_req_i : m0_req_i;
        end else if (m0_req_i && m1_req_i) begin
            sel_vld  = 1'b1;
            sel_port = rr_q;
        end else if (m0_req_i) begin
            sel_vld  = 1'b1;
            sel_port = 1'b0;
        end else if (m1_req_i) begin
            sel_vld  = 1'b1;
            sel_port = 1'b1;
        end
    end

    assign full         = (count_q == CntFull);
    assign instr_req_o  = rst_ni & sel_vld & ~full;
    assign instr_addr_o = (rst_ni & sel_vld) ? (sel_port ? m1_addr_i : m0_addr_i) : 32'h0;

    assign push     = instr_req_o & instr_gnt_i;
    assign m0_gnt_o = push & ~sel_port;
    assign m1_gnt_o = push & sel_port;

    // Responses with no outstanding transaction are dropped rather than routed.
    assign pop         = instr_rvalid_i & (count_q != '0);
    assign head_owner  = owner_q[rd_ptr_q];
    assign m0_rvalid_o = pop & ~head_owner;
    assign m1_rvalid_o = pop & head_owner;
    assign m0_err_o    = m0_rvalid_o & instr_err_i;
    assign m1_err_o    = m1_rvalid_o & instr_err_i;
    assign rdata_o     = instr_rdata_i;

    assign busy_o = instr_req_o | (count_q != '0) | lock_q;

    always_comb begin
        rr_d         = rr_q;
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        owner_d      = owner_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        if (push) begin
            rr_d              = ~sel_port;
            lock_d            = 1'b0;
            owner_d[wr_ptr_q] = sel_port;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end else if (instr_req_o) begin
            lock_d       = 1'b1;
            lock_owner_d = sel_port;
        end

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q         <= 1'b0;
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
            owner_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            rr_q         <= rr_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            owner_q      <= owner_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    a_one_grant: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(m0_gnt_o && m1_gnt_o));
    a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= CntFull);
    a_addr_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_req_o |-> !$isunknown(instr_addr_o));
    a_addr_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_req_o |-> (instr_addr_o[1:0] == 2'b00));
    a_lock_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lock_q |-> (lock_owner_q ? m1_req_i : m0_req_i));
    a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_rvalid_i |-> (count_q != '0));

endmodule

// File: tb/tb_cve2_instr_bus_arbiter.sv
// Bench for cve2_instr_bus_arbiter: directed scenarios plus randomized OBI traffic against a queue-based model.
module tb_cve2_instr_bus_arbiter;

    localparam int MAXO = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        m0_req_i, m1_req_i;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0] rdata_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i, instr_rvalid_i, instr_err_i;
    logic [31:0] instr_rdata_i;
    logic        busy_o;

    always #5 clk_i = ~clk_i;

    cve2_instr_bus_arbiter #(.MaxOutstanding(MAXO)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .m0_req_i       (m0_req_i),
        .m0_addr_i      (m0_addr_i),
        .m0_gnt_o       (m0_gnt_o),
        .m0_rvalid_o    (m0_rvalid_o),
        .m0_err_o       (m0_err_o),
        .m1_req_i       (m1_req_i),
        .m1_addr_i      (m1_addr_i),
        .m1_gnt_o       (m1_gnt_o),
        .m1_rvalid_o    (m1_rvalid_o),
        .m1_err_o       (m1_err_o),
        .rdata_o        (rdata_o),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .busy_o         (busy_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: queue of issuing ports in grant order, the port stalled on a pending request, and who wins a tie.
    int q[$];
    int lock_own = -1;
    int tie_port = 0;

    logic        e_req, e_g0, e_g1, e_rv0, e_rv1, e_er0, e_er1, e_busy;
    logic [31:0] e_addr;
    int          e_sel;

    logic        c_req, c_g0, c_g1, c_rv0, c_rv1, c_er0, c_er1, c_busy;
    logic [31:0] c_addr, c_rdata;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    function automatic void model_eval();
        logic selreq;
        selreq = 1'b0;
        e_sel  = -1;
        {e_req, e_g0, e_g1, e_rv0, e_rv1, e_er0, e_er1, e_busy} = '0;
        e_addr = 32'h0;
        if (rst_ni) begin
            if (lock_own >= 0) begin
                e_sel  = lock_own;
                selreq = (lock_own == 1) ? m1_req_i : m0_req_i;
            end else if (m0_req_i && m1_req_i) begin
                e_sel  = tie_port;
                selreq = 1'b1;
            end else if (m0_req_i) begin
                e_sel  = 0;
                selreq = 1'b1;
            end else if (m1_req_i) begin
                e_sel  = 1;
                selreq = 1'b1;
            end
            e_req  = selreq && (q.size() < MAXO);
            e_addr = selreq ? ((e_sel == 1) ? m1_addr_i : m0_addr_i) : 32'h0;
            e_g0   = instr_gnt_i && e_req && (e_sel == 0);
            e_g1   = instr_gnt_i && e_req && (e_sel == 1);
            if (instr_rvalid_i && q.size() > 0) begin
                e_rv0 = (q[0] == 0);
                e_rv1 = (q[0] == 1);
            end
            e_er0  = e_rv0 && instr_err_i;
            e_er1  = e_rv1 && instr_err_i;
            e_busy = e_req || (q.size() > 0) || (lock_own >= 0);
        end
    endfunction

    function automatic void model_advance();
        if (!rst_ni) begin
            q.delete();
            lock_own = -1;
            tie_port = 0;
        end else begin
            if (e_rv0 || e_rv1) void'(q.pop_front());
            if (e_g0 || e_g1) begin
                q.push_back(e_sel);
                tie_port = 1 - e_sel;
                lock_own = -1;
            end else if (e_req) begin
                lock_own = e_sel;
            end
        end
    endfunction

    // One bus cycle: drive inputs, compare every output against the model, then cross the clock edge.
    task automatic step(input logic rst, input logic r0, input logic [31:0] a0,
                        input logic r1, input logic [31:0] a1, input logic gnt,
                        input logic rv, input logic [31:0] rd, input logic er);
        rst_ni         = rst;
        m0_req_i       = r0;
        m0_addr_i      = a0;
        m1_req_i       = r1;
        m1_addr_i      = a1;
        instr_gnt_i    = gnt;
        instr_rvalid_i = rv;
        instr_rdata_i  = rd;
        instr_err_i    = er;
        #2;
        model_eval();
        c_req = instr_req_o; c_addr = instr_addr_o; c_busy = busy_o; c_rdata = rdata_o;
        c_g0 = m0_gnt_o; c_g1 = m1_gnt_o; c_rv0 = m0_rvalid_o; c_rv1 = m1_rvalid_o;
        c_er0 = m0_err_o; c_er1 = m1_err_o;
        chk("instr_req", c_req, e_req);
        chk("instr_addr", c_addr, e_addr);
        chk("m0_gnt", c_g0, e_g0);
        chk("m1_gnt", c_g1, e_g1);
        chk("m0_rvalid", c_rv0, e_rv0);
        chk("m1_rvalid", c_rv1, e_rv1);
        chk("m0_err", c_er0, e_er0);
        chk("m1_err", c_er1, e_er1);
        chk("busy", c_busy, e_busy);
        chk("rdata", c_rdata, rd);
        model_advance();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input logic rv, input logic [31:0] rd, input logic er);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, rv, rd, er);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst_req", c_req, 1'b0);
        chk("rst_busy", c_busy, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    logic        rq0, rq1, rst_r, rv_r;
    logic [31:0] ad0, ad1;

    initial begin
        // Reset with requests pending: everything but rdata stays low.
        step(1'b0, 1'b1, 32'h80, 1'b1, 32'h90, 1'b1, 1'b1, 32'hABCD_0000, 1'b1);
        chk("rst_gnt0", c_g0, 1'b0);
        chk("rst_rdata_passthru", c_rdata, 32'hABCD_0000);
        do_reset();

        // Single fetch with a response in the following cycle.
        step(1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t1_m0_gnt", c_g0, 1'b1);
        chk("t1_addr", c_addr, 32'h80);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h13, 1'b0);
        chk("t1_m0_rvalid", c_rv0, 1'b1);
        chk("t1_rdata", c_rdata, 32'h13);
        chk("t1_m1_rvalid", c_rv1, 1'b0);

        // Two continuous requesters alternate, responses follow grant order.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1, (i > 0), 32'h100 + i, 1'b0);
            chk("t2_gnt0", c_g0, (i % 2 == 0));
            chk("t2_gnt1", c_g1, (i % 2 == 1));
            if (i > 0) chk("t2_rv0", c_rv0, ((i - 1) % 2 == 0));
        end
        idle(1'b1, 32'h0, 1'b0);
        chk("t2_rv1_last", c_rv1, 1'b1);

        // A stalled request holds its address and blocks the other port until granted.
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t3_addr_c0", c_addr, 32'h100);
        for (int i = 1; i < 3; i++) begin
            step(1'b1, 1'b1, 32'h200, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
            chk("t3_addr_held", c_addr, 32'h100);
        end
        step(1'b1, 1'b1, 32'h200, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t3_m1_gnt_c3", c_g1, 1'b1);
        chk("t3_addr_c3", c_addr, 32'h100);
        step(1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t3_m0_gnt_c4", c_g0, 1'b1);
        chk("t3_addr_c4", c_addr, 32'h200);
        idle(1'b1, 32'h0, 1'b0);
        chk("t3_rv1", c_rv1, 1'b1);
        idle(1'b1, 32'h0, 1'b0);
        chk("t3_rv0", c_rv0, 1'b1);

        // Full tracker: grants stop, a response reopens issue only on the next cycle.
        do_reset();
        step(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t4_gnt_a", c_g0, 1'b1);
        step(1'b1, 1'b1, 32'h44, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t4_gnt_b", c_g0, 1'b1);
        step(1'b1, 1'b1, 32'h48, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t4_full_req", c_req, 1'b0);
        chk("t4_full_busy", c_busy, 1'b1);
        step(1'b1, 1'b1, 32'h48, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0);
        chk("t4_pop_rv0", c_rv0, 1'b1);
        chk("t4_pop_no_req", c_req, 1'b0);
        step(1'b1, 1'b1, 32'h48, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t4_regrant", c_g0, 1'b1);
        idle(1'b1, 32'h0, 1'b0);
        idle(1'b1, 32'h0, 1'b0);
        chk("t4_drain_rv0", c_rv0, 1'b1);
        idle(1'b0, 32'h0, 1'b0);
        chk("t4_idle_busy", c_busy, 1'b0);

        // Error routed to the port that issued the second transaction.
        do_reset();
        step(1'b1, 1'b1, 32'h10, 1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t5_g0", c_g0, 1'b1);
        step(1'b1, 1'b1, 32'h14, 1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t5_g1", c_g1, 1'b1);
        step(1'b1, 1'b1, 32'h14, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0);
        chk("t5_rv0_a", c_rv0, 1'b1);
        chk("t5_err0_a", c_er0, 1'b0);
        step(1'b1, 1'b1, 32'h14, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t5_g0_b", c_g0, 1'b1);
        idle(1'b1, 32'h0, 1'b1);
        chk("t5_rv1", c_rv1, 1'b1);
        chk("t5_err1", c_er1, 1'b1);
        chk("t5_no_rv0", c_rv0, 1'b0);
        idle(1'b1, 32'h0, 1'b0);
        chk("t5_rv0_b", c_rv0, 1'b1);
        chk("t5_err0_b", c_er0, 1'b0);

        // Reset while a transaction is outstanding and a request is stalled.
        do_reset();
        step(1'b1, 1'b1, 32'h50, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t6_stalled_req", c_req, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t6_rst_req", c_req, 1'b0);
        chk("t6_rst_busy", c_busy, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h60, 1'b0, 1'b1, 32'h0, 1'b0);
        chk("t6_rst_rv0", c_rv0, 1'b0);
        chk("t6_rst_rv1", c_rv1, 1'b0);
        idle(1'b0, 32'h0, 1'b0);
        chk("t6_post_busy", c_busy, 1'b0);
        step(1'b1, 1'b1, 32'h70, 1'b1, 32'h74, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t6_tie_to_port0", c_g0, 1'b1);
        idle(1'b1, 32'h0, 1'b0);

        // Randomized traffic: masters hold requests until granted, memory answers in order.
        rq0 = 1'b0; rq1 = 1'b0; ad0 = 32'h0; ad1 = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!rq0 && $urandom_range(0, 2) != 0) begin
                rq0 = 1'b1;
                ad0 = $urandom() & 32'hFFFF_FFFC;
            end
            if (!rq1 && $urandom_range(0, 1) != 0) begin
                rq1 = 1'b1;
                ad1 = $urandom() & 32'hFFFF_FFFC;
            end
            rst_r = ($urandom_range(0, 299) != 0);
            rv_r  = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            step(rst_r, rq0, ad0, rq1, ad1, ($urandom_range(0, 3) != 0), rv_r, $urandom(),
                 ($urandom_range(0, 3) == 0));
            if (e_g0) rq0 = 1'b0;
            if (e_g1) rq1 = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
